// File: rtl/psum_acc_pkg.sv
// Shared constants and width helpers for the psum channel accumulator.
package psum_acc_pkg;

   // Output mode selected by sat_en
   localparam logic SAT_MODE_WRAP  = 1'b0;
   localparam logic SAT_MODE_CLAMP = 1'b1;

   function automatic int clog2(input int unsigned n);
      int          r;
      int unsigned v;
      r = 0;
      v = 1;
      while (v < n) begin
         v = v << 1;
         r = r + 1;
      end
      return r;
   endfunction

   // Enough headroom to sum `channels` IN_W-bit psums without overflow
   function automatic int acc_width(input int in_w, input int channels);
      return in_w + clog2(channels) + 1;
   endfunction

   // Counter width, at least one bit even for a single-entry range
   function automatic int idx_width(input int n);
      return (n > 1) ? clog2(n) : 1;
   endfunction

endpackage

// File: rtl/psum_sat_relu.sv
// Final-channel post-processing: optional ReLU, then saturate or wrap to OUT_W.
module psum_sat_relu
   import psum_acc_pkg::*;
#(
   parameter int ACC_W = 24,
   parameter int OUT_W = 21
)(
   input  logic [ACC_W-1:0] sum,
   input  logic             relu_en,
   input  logic             sat_en,
   output logic [OUT_W-1:0] result,
   output logic             clipped
);

   logic [ACC_W-1:0] rect;

   // Clamp negative sums to zero when ReLU is enabled
   always_comb begin
      rect = sum;
      if (relu_en && sum[ACC_W-1])
         rect = '0;
   end

   generate
      if (OUT_W < ACC_W) begin : g_narrow
         logic [ACC_W-OUT_W:0] hi;
         logic                 over;

         // Out of range when the bits above the OUT_W sign bit are not a pure sign extension
         always_comb begin
            hi      = rect[ACC_W-1:OUT_W-1];
            over    = ~((&hi) | ~(|hi));
            clipped = over;
            result  = rect[OUT_W-1:0];
            if (over && (sat_en == SAT_MODE_CLAMP))
               result = rect[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                      : {1'b0, {(OUT_W-1){1'b1}}};
         end
      end else begin : g_full
         logic unused_sat_en;

         // Output as wide as the accumulator: nothing can clip
         always_comb begin
            unused_sat_en = sat_en;
            clipped       = 1'b0;
            result        = rect[OUT_W-1:0];
         end
      end
   endgenerate

endmodule

// File: rtl/psum_channel_acc.sv
// Channel-major psum reducer: per-batch running sums, one OUT_W result per batch.
module psum_channel_acc
   import psum_acc_pkg::*;
#(
   parameter int BATCHES  = 4,
   parameter int CHANNELS = 3,
   parameter int IN_W     = 21,
   parameter int OUT_W    = 21,
   parameter int ACC_W    = acc_width(IN_W, CHANNELS)
)(
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             sat_en,
   input  logic             relu_en,
   input  logic [IN_W-1:0]  in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [OUT_W-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_last,
   output logic             sat_flag
);

   localparam int BW = idx_width(BATCHES);
   localparam int CW = idx_width(CHANNELS);
   localparam logic [BW-1:0] B_LAST = BW'(BATCHES - 1);
   localparam logic [CW-1:0] C_LAST = CW'(CHANNELS - 1);

   logic [BW-1:0]    batch_idx, cur_b, nxt_b;
   logic [CW-1:0]    ch_idx, cur_c, nxt_c;
   logic [ACC_W-1:0] acc [BATCHES];
   logic [ACC_W-1:0] base, sum;
   logic             accept, last_ch;
   logic [OUT_W-1:0] result;
   logic             clipped;

   assign in_ready = ~out_valid | out_ready;

   // Position of the current beat (start forces c0b0), running sum and next counters
   always_comb begin
      accept  = in_valid & in_ready;
      cur_b   = start ? '0 : batch_idx;
      cur_c   = start ? '0 : ch_idx;
      last_ch = (cur_c == C_LAST);
      base    = (cur_c == '0) ? '0 : acc[cur_b];
      sum     = base + {{(ACC_W-IN_W){in_data[IN_W-1]}}, in_data};
      nxt_b   = cur_b;
      nxt_c   = cur_c;
      if (accept) begin
         if (cur_b == B_LAST) begin
            nxt_b = '0;
            nxt_c = last_ch ? '0 : cur_c + 1'b1;
         end else begin
            nxt_b = cur_b + 1'b1;
         end
      end
   end

   psum_sat_relu #(
      .ACC_W (ACC_W),
      .OUT_W (OUT_W)
   ) u_sat_relu (
      .sum     (sum),
      .relu_en (relu_en),
      .sat_en  (sat_en),
      .result  (result),
      .clipped (clipped)
   );

   // Batch/channel counters
   always_ff @(posedge clock) begin
      if (reset) begin
         batch_idx <= '0;
         ch_idx    <= '0;
      end else begin
         batch_idx <= nxt_b;
         ch_idx    <= nxt_c;
      end
   end

   // Per-batch running sums; the final channel goes straight to the output
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int unsigned i = 0; i < BATCHES; i++)
            acc[i] <= '0;
      end else if (accept && !last_ch) begin
         acc[cur_b] <= sum;
      end
   end

   // Output register with hold under backpressure, plus sticky clip flag
   always_ff @(posedge clock) begin
      if (reset) begin
         out_data  <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         sat_flag  <= 1'b0;
      end else begin
         if (accept && last_ch) begin
            out_data  <= result;
            out_valid <= 1'b1;
            out_last  <= (cur_b == B_LAST);
         end else if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
         end
         // A clip on a beat accepted with start belongs to the new frame, so it wins
         if (accept && last_ch && clipped)
            sat_flag <= 1'b1;
         else if (start)
            sat_flag <= 1'b0;
      end
   end

endmodule

// File: tb/tb_psum_channel_acc.sv
// Self-checking bench: vector table, hand sequences and randomized model comparison.
module tb_psum_channel_acc;

   localparam int     IN_W  = 21;
   localparam int     OUT_W = 21;
   localparam int     B     = 4;
   localparam int     C     = 3;
   localparam longint OMAX  = 1048575;
   localparam longint OMIN  = -1048576;

   logic             clock = 1'b0;
   logic             reset, start, sat_en, relu_en, in_valid, in_ready;
   logic             out_valid, out_ready, out_last, sat_flag;
   logic [IN_W-1:0]  in_data;
   logic [OUT_W-1:0] out_data;

   logic             s_start, s_sat_en, s_relu_en, s_in_valid, s_in_ready;
   logic             s_out_valid, s_out_ready, s_out_last, s_sat_flag;
   logic [IN_W-1:0]  s_in_data;
   logic [OUT_W-1:0] s_out_data;

   int checks = 0;
   int errors = 0;

   typedef struct {
      bit     st;
      bit     v;
      longint d;
      bit     sat;
      bit     relu;
      bit     ev;
      longint ed;
      bit     el;
      bit     ef;
   } vec_t;

   vec_t   tbl[$];
   longint ten [3] = '{1, 10, 100};
   longint f2 [3][4] = '{'{1048575, -1048576, -5, 5},
                         '{1048575, -1048576,  2, -2},
                         '{1048575, -1048576,  1, 1}};
   longint e2 [4] = '{1048575, -1048576, 0, 4};
   longint e3 [4] = '{1048573, -1048576, -2, 4};

   // Free-running clock
   always #5 clock = ~clock;

   psum_channel_acc #(.BATCHES(B), .CHANNELS(C), .IN_W(IN_W), .OUT_W(OUT_W)) dut (
      .clock(clock), .reset(reset), .start(start), .sat_en(sat_en), .relu_en(relu_en),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_last(out_last), .sat_flag(sat_flag)
   );

   psum_channel_acc #(.BATCHES(2), .CHANNELS(1), .IN_W(IN_W), .OUT_W(OUT_W)) dut1 (
      .clock(clock), .reset(reset), .start(s_start), .sat_en(s_sat_en), .relu_en(s_relu_en),
      .in_data(s_in_data), .in_valid(s_in_valid), .in_ready(s_in_ready),
      .out_data(s_out_data), .out_valid(s_out_valid), .out_ready(s_out_ready),
      .out_last(s_out_last), .sat_flag(s_sat_flag)
   );

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   function automatic longint sval(input logic [OUT_W-1:0] x);
      return longint'($signed(x));
   endfunction

   task automatic push(input bit st, input bit v, input longint d, input bit sat, input bit relu,
                       input bit ev, input longint ed, input bit el, input bit ef);
      vec_t r;
      r.st = st; r.v = v; r.d = d; r.sat = sat; r.relu = relu;
      r.ev = ev; r.ed = ed; r.el = el; r.ef = ef;
      tbl.push_back(r);
   endtask

   task automatic apply_row(input int i);
      vec_t r;
      r         = tbl[i];
      start     = r.st;
      in_valid  = r.v;
      in_data   = IN_W'(r.d);
      sat_en    = r.sat;
      relu_en   = r.relu;
      out_ready = 1'b1;
      step();
      start    = 1'b0;
      in_valid = 1'b0;
      check($sformatf("row%0d out_valid", i), out_valid, r.ev);
      if (r.ev) begin
         check($sformatf("row%0d out_data", i), sval(out_data), r.ed);
         check($sformatf("row%0d out_last", i), out_last, r.el);
      end
      check($sformatf("row%0d sat_flag", i), sat_flag, r.ef);
   endtask

   // Reference reduction: ReLU, then saturate or wrap to OUT_W
   function automatic longint reduce(input longint v, input bit sat, input bit relu, output bit clip);
      longint x, w;
      x    = (relu && v < 0) ? 0 : v;
      clip = (x > OMAX) || (x < OMIN);
      if (sat) begin
         w = (x > OMAX) ? OMAX : (x < OMIN) ? OMIN : x;
      end else begin
         w = x & 64'h1F_FFFF;
         if (w > OMAX) w = w - 2097152;
      end
      return w;
   endfunction

   int     pos;
   longint macc [B];
   bit     m_ov, m_last, m_flag;
   longint m_data;

   initial begin
      // Frame 1: plain sums (rows 0..12)
      for (int k = 0; k < B*C; k++)
         push(0, 1, (k%B + 1) * ten[k/B], 1, 0, (k/B == C-1), 111 * (k%B + 1), (k%B == B-1), 0);
      push(0, 0, 0, 1, 0, 0, 0, 0, 0);
      // Frame 2: saturation and ReLU; relu_en on non-final rows of batch 1 must be ignored
      for (int k = 0; k < B*C; k++)
         push(0, 1, f2[k/B][k%B], 1, ((k/B == C-1) && (k%B >= 2)) || ((k/B < C-1) && (k%B == 1)),
              (k/B == C-1), e2[k%B], (k%B == B-1), (k/B == C-1));
      // Frame 3: wrap mode, start on first beat; sat_en only high on non-final rows
      for (int k = 0; k < B*C; k++)
         push((k == 0), 1, f2[k/B][k%B], (k/B < C-1), 0,
              (k/B == C-1), e3[k%B], (k%B == B-1), (k/B == C-1));
      // start mid-frame after 5 beats; 7 becomes c0b0
      for (int k = 0; k < 5; k++)
         push(0, 1, (k%B + 1) * ten[k/B], 1, 0, 0, 0, 0, 1);
      push(1, 1, 7, 1, 0, 0, 0, 0, 0);
      for (int k = 1; k < B*C; k++)
         push(0, 1, (k%B + 1) * ten[k/B], 1, 0, (k/B == C-1),
              (k%B == 0) ? 117 : 111 * (k%B + 1), (k%B == B-1), 0);

      reset = 1'b1; start = 1'b0; sat_en = 1'b1; relu_en = 1'b0;
      in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
      s_start = 1'b0; s_sat_en = 1'b1; s_relu_en = 1'b0;
      s_in_valid = 1'b0; s_in_data = '0; s_out_ready = 1'b1;
      step();
      step();
      check("reset out_valid", out_valid, 0);
      check("reset out_data", sval(out_data), 0);
      check("reset out_last", out_last, 0);
      check("reset sat_flag", sat_flag, 0);
      check("reset in_ready", in_ready, 1);
      reset = 1'b0;

      for (int i = 0; i < tbl.size(); i++)
         apply_row(i);

      // Backpressure: hold 111 for 5 cycles, then drain the rest
      sat_en = 1'b1; relu_en = 1'b0; out_ready = 1'b1;
      for (int k = 0; k < 9; k++) begin
         in_valid = 1'b1;
         in_data  = IN_W'((k%B + 1) * ten[k/B]);
         step();
      end
      check("bp first valid", out_valid, 1);
      check("bp first data", sval(out_data), 111);
      in_data   = IN_W'(200);
      out_ready = 1'b0;
      for (int n = 0; n < 5; n++) begin
         #1;
         check($sformatf("bp hold%0d in_ready", n), in_ready, 0);
         step();
         check($sformatf("bp hold%0d valid", n), out_valid, 1);
         check($sformatf("bp hold%0d data", n), sval(out_data), 111);
      end
      out_ready = 1'b1;
      for (int k = 9; k < B*C; k++) begin
         in_data = IN_W'((k%B + 1) * ten[k/B]);
         step();
         check($sformatf("bp drain%0d valid", k), out_valid, 1);
         check($sformatf("bp drain%0d data", k), sval(out_data), 111 * (k%B + 1));
         check($sformatf("bp drain%0d last", k), out_last, (k == B*C-1));
      end
      in_valid = 1'b0;
      step();
      check("bp idle valid", out_valid, 0);

      // CHANNELS=1, BATCHES=2 pass-through
      s_in_valid = 1'b1;
      s_in_data  = IN_W'(-3);
      step();
      check("c1 b0 valid", s_out_valid, 1);
      check("c1 b0 data", sval(s_out_data), -3);
      check("c1 b0 last", s_out_last, 0);
      s_in_data = IN_W'(9);
      step();
      check("c1 b1 valid", s_out_valid, 1);
      check("c1 b1 data", sval(s_out_data), 9);
      check("c1 b1 last", s_out_last, 1);
      s_in_valid = 1'b0;
      step();
      check("c1 idle valid", s_out_valid, 0);

      // Reset mid-frame discards the partial frame
      for (int i = 0; i < 5; i++)
         apply_row(i);
      reset    = 1'b1;
      in_valid = 1'b1;
      in_data  = IN_W'(5);
      step();
      reset    = 1'b0;
      in_valid = 1'b0;
      check("midreset valid", out_valid, 0);
      check("midreset data", sval(out_data), 0);
      check("midreset flag", sat_flag, 0);
      for (int i = 0; i <= B*C; i++)
         apply_row(i);

      // Randomized traffic against the reference model
      reset = 1'b1;
      step();
      reset = 1'b0;
      pos = 0; m_ov = 0; m_last = 0; m_flag = 0; m_data = 0;
      for (int b = 0; b < B; b++) macc[b] = 0;
      for (int n = 0; n < 3000; n++) begin
         bit     st, v, rdy, sat, relu, exp_rdy, loaded, clip;
         longint d;
         int     bi, ci;
         st   = ($urandom_range(0, 49) == 0);
         v    = ($urandom_range(0, 3) != 0);
         rdy  = ($urandom_range(0, 3) != 0);
         sat  = $urandom_range(0, 1) != 0;
         relu = $urandom_range(0, 1) != 0;
         case ($urandom_range(0, 2))
            0:       d = longint'($urandom_range(0, 2097151)) - 1048576;
            1:       d = longint'($urandom_range(0, 2000)) - 1000;
            default: d = ($urandom_range(0, 1) != 0) ? OMAX : OMIN;
         endcase
         start = st; in_valid = v; out_ready = rdy; sat_en = sat; relu_en = relu;
         in_data = IN_W'(d);
         #1;
         exp_rdy = !m_ov || rdy;
         check($sformatf("rand%0d in_ready", n), in_ready, exp_rdy);
         loaded = 0;
         if (st) begin
            pos    = 0;
            m_flag = 0;
         end
         if (v && exp_rdy) begin
            bi = pos % B;
            ci = pos / B;
            if (ci == 0) macc[bi] = 0;
            macc[bi] = macc[bi] + d;
            if (ci == C-1) begin
               m_data = reduce(macc[bi], sat, relu, clip);
               m_last = (bi == B-1);
               loaded = 1;
               if (clip) m_flag = 1;
            end
            pos = (pos + 1) % (B*C);
         end
         if (loaded) m_ov = 1;
         else if (rdy) m_ov = 0;
         step();
         check($sformatf("rand%0d out_valid", n), out_valid, m_ov);
         if (m_ov) begin
            check($sformatf("rand%0d out_data", n), sval(out_data), m_data);
            check($sformatf("rand%0d out_last", n), out_last, m_last);
         end
         check($sformatf("rand%0d sat_flag", n), sat_flag, m_flag);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
